// File: rtl/mu0_pkg.sv
// Shared protocol byte codes and controller state encoding for the MU0 host command link.
package mu0_pkg;

    localparam logic [7:0] CMD_PING  = 8'h70; // 'p'
    localparam logic [7:0] CMD_READ  = 8'h72; // 'r'
    localparam logic [7:0] CMD_WRITE = 8'h77; // 'w'
    localparam logic [7:0] CMD_EXEC  = 8'h78; // 'x'
    localparam logic [7:0] CMD_STAT  = 8'h73; // 's'

    localparam logic [7:0] RSP_PING  = 8'h50; // 'P'
    localparam logic [7:0] RSP_OK    = 8'h4B; // 'K'
    localparam logic [7:0] RSP_EXEC  = 8'h58; // 'X'
    localparam logic [7:0] RSP_RUN   = 8'h2B; // '+'
    localparam logic [7:0] RSP_STOP  = 8'h2D; // '-'
    localparam logic [7:0] RSP_UNK   = 8'h3F; // '?'
    localparam logic [7:0] RSP_BUSY  = 8'h21; // '!'

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REPLY,
        ST_RX_HI,
        ST_RX_LO,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_TX_HI,
        ST_TX_LO
    } state_e;

endpackage

// File: rtl/host_cmd_ctrl_tx_sched.sv
// UART transmit scheduler: fires tx_start in the same cycle as a request when the transmitter is idle.
// Never fires on consecutive cycles; tx_data holds the last sent byte until the next start.
module host_cmd_ctrl_tx_sched (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       start_o,
    output logic [7:0] tx_data_o
);

    logic       last_q;
    logic [7:0] hold_q;

    // last_q covers the one cycle before tx_busy rises after a start
    assign start_o   = req_i && !tx_busy_i && !last_q;
    assign tx_data_o = start_o ? byte_i : hold_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b0;
            hold_q <= 8'h00;
        end else begin
            last_q <= start_o;
            if (start_o) begin
                hold_q <= byte_i;
            end
        end
    end

endmodule

// File: rtl/host_cmd_ctrl.sv
// Host command controller: decodes UART command bytes into program RAM load/dump, CPU start and status replies.
// One byte per accepted command; replies and dump bytes wait on tx_busy, bytes arriving outside IDLE/RX_HI/RX_LO are dropped.
module host_cmd_ctrl
    import mu0_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              tx_busy_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [15:0]       mem_rdata_i,
    output logic              mem_grant_o,
    output logic              cpu_start_o,
    input  logic              cpu_running_i
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_WORDS - 1);
    localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [ADDR_W:0] addr_q, addr_d;
    logic [15:0]     word_q, word_d;
    logic [7:0]      reply_q, reply_d;
    logic            grant_q, grant_d;
    logic            cpu_start_q, cpu_start_d;
    logic            tx_req, tx_go;
    logic [7:0]      tx_byte;
    logic            mem_we, mem_re;

    host_cmd_ctrl_tx_sched u_tx_sched (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (tx_req),
        .byte_i    (tx_byte),
        .tx_busy_i (tx_busy_i),
        .start_o   (tx_go),
        .tx_data_o (tx_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            word_q      <= 16'h0000;
            reply_q     <= 8'h00;
            grant_q     <= 1'b0;
            cpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            reply_q     <= reply_d;
            grant_q     <= grant_d;
            cpu_start_q <= cpu_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        reply_d     = reply_q;
        grant_d     = grant_q;
        cpu_start_d = 1'b0;
        tx_req      = 1'b0;
        tx_byte     = reply_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    state_d = ST_REPLY;
                    case (rx_data_i)
                        CMD_PING: reply_d = RSP_PING;
                        CMD_STAT: reply_d = cpu_running_i ? RSP_RUN : RSP_STOP;
                        CMD_EXEC: begin
                            if (cpu_running_i) begin
                                reply_d = RSP_BUSY;
                            end else begin
                                reply_d     = RSP_EXEC;
                                cpu_start_d = 1'b1;
                            end
                        end
                        CMD_WRITE: begin
                            if (cpu_running_i) begin
                                reply_d = RSP_BUSY;
                            end else begin
                                state_d = ST_RX_HI;
                                addr_d  = '0;
                                grant_d = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            if (cpu_running_i) begin
                                reply_d = RSP_BUSY;
                            end else begin
                                state_d = ST_RD_REQ;
                                addr_d  = '0;
                                grant_d = 1'b1;
                            end
                        end
                        default: reply_d = RSP_UNK;
                    endcase
                end
            end
            ST_REPLY: begin
                tx_req  = 1'b1;
                tx_byte = reply_q;
                if (tx_go) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_HI: begin
                if (rx_valid_i) begin
                    word_d[15:8] = rx_data_i;
                    state_d      = ST_RX_LO;
                end
            end
            ST_RX_LO: begin
                if (rx_valid_i) begin
                    word_d[7:0] = rx_data_i;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                addr_d = addr_q + ADDR_ONE;
                if (addr_q == LAST_ADDR) begin
                    reply_d = RSP_OK;
                    state_d = ST_REPLY;
                end else begin
                    state_d = ST_RX_HI;
                end
            end
            ST_RD_REQ: begin
                mem_re  = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                word_d  = mem_rdata_i;
                state_d = ST_TX_HI;
            end
            ST_TX_HI: begin
                tx_req  = 1'b1;
                tx_byte = word_q[15:8];
                if (tx_go) begin
                    state_d = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                tx_req  = 1'b1;
                tx_byte = word_q[7:0];
                if (tx_go) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = (addr_q == LAST_ADDR) ? ST_IDLE : ST_RD_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            grant_d = 1'b0;
        end
    end

    assign tx_start_o  = tx_go;
    assign mem_addr_o  = addr_q[ADDR_W-1:0];
    assign mem_wdata_o = word_q;
    assign mem_we_o    = mem_we;
    assign mem_re_o    = mem_re;
    assign mem_grant_o = grant_q;
    assign cpu_start_o = cpu_start_q;

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Bench for host_cmd_ctrl: command vector table, RAM load/dump streams and mid-transfer reset.
module tb_host_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_grant;
    logic        cpu_start;
    logic        cpu_running;

    always #5 clk = ~clk;

    host_cmd_ctrl #(.ADDR_W(8), .MEM_WORDS(256)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .tx_busy_i     (tx_busy),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_we_o      (mem_we),
        .mem_re_o      (mem_re),
        .mem_rdata_i   (mem_rdata),
        .mem_grant_o   (mem_grant),
        .cpu_start_o   (cpu_start),
        .cpu_running_i (cpu_running)
    );

    // UART transmitter: busy for 3 cycles, rising the cycle after tx_start
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start && busy_cnt == 0) busy_cnt <= 3;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [7:0] cmd;
        logic       run;
        logic [7:0] rsp;
        int         starts;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         wr_cnt = 0;
    int         re_cnt = 0;
    int         cs_cnt = 0;
    bit         grant_seen = 0;
    logic       prev_start = 1'b0;
    logic       prev_cs = 1'b0;
    logic [7:0] held = 8'h00;
    vec_t       vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                check("tx_while_busy", 32'(tx_busy), 32'd0);
                check("tx_back_to_back", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %0h expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e));
                end
                held = tx_data;
            end else if (tx_busy && tx_data !== held) begin
                check("tx_data_hold", 32'(tx_data), 32'(held));
            end
            if (mem_we) begin
                check("wr_addr", 32'(mem_addr), 32'(wr_cnt[7:0]));
                check("wr_data", 32'(mem_wdata), 32'({8'(2 * wr_cnt), 8'(2 * wr_cnt + 1)}));
                wr_cnt++;
            end
            if (mem_re) begin
                check("rd_addr", 32'(mem_addr), 32'(re_cnt[7:0]));
                re_cnt++;
            end
            if ((mem_we || mem_re) && !mem_grant) begin
                check("access_without_grant", 32'(mem_grant), 32'd1);
            end
            if (cpu_start) begin
                cs_cnt++;
                check("cpu_start_under_grant", 32'(mem_grant), 32'd0);
                check("cpu_start_width", 32'(prev_cs), 32'd0);
            end
            if (mem_grant) grant_seen = 1;
            prev_start = tx_start;
            prev_cs    = cpu_start;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, 32'({tx_start, mem_we, mem_re, mem_grant, cpu_start}), 32'd0);
        check({name, "_data"}, {tx_data, mem_addr, mem_wdata}, 32'd0);
    endtask

    initial begin
        int cs0;
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        cpu_running = 1'b0;

        vecs[0] = '{"p", 1'b0, "P", 0};
        vecs[1] = '{"s", 1'b1, "+", 0};
        vecs[2] = '{"s", 1'b0, "-", 0};
        vecs[3] = '{"x", 1'b1, "!", 0};
        vecs[4] = '{"x", 1'b0, "X", 1};
        vecs[5] = '{"q", 1'b0, "?", 0};
        vecs[6] = '{"r", 1'b1, "!", 0};
        vecs[7] = '{"w", 1'b1, "!", 0};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            cpu_running = vecs[i].run;
            cs0         = cs_cnt;
            grant_seen  = 0;
            @(negedge clk);
            exp_q.push_back(vecs[i].rsp);
            send(vecs[i].cmd, 0);
            wait_drain(200, "cmd_reply");
            repeat (6) @(negedge clk);
            check("cpu_start_count", 32'(cs_cnt - cs0), 32'(vecs[i].starts));
            check("grant_stays_low", 32'(grant_seen), 32'd0);
        end
        cpu_running = 1'b0;

        // Full RAM load: byte n = n mod 256, finished by 'K'
        wr_cnt = 0;
        exp_q.push_back("K");
        send("w", 2);
        for (int n = 0; n < 512; n++) send(8'(n), 2);
        wait_drain(500, "write_reply");
        repeat (5) @(negedge clk);
        check("write_count", 32'(wr_cnt), 32'd256);
        check("ram_word0", 32'(ram[0]), 32'h0001);
        check("ram_word100", 32'(ram[100]), 32'hC8C9);
        check("ram_word255", 32'(ram[255]), 32'hFEFF);
        check("grant_after_write", 32'(mem_grant), 32'd0);

        // Dump: same stream back, stray bytes ignored, nothing trailing
        re_cnt = 0;
        for (int n = 0; n < 512; n++) exp_q.push_back(8'(n));
        send("r", 20);
        send("p", 30);
        send("q", 0);
        wait_drain(8000, "read_stream");
        repeat (40) @(negedge clk);
        check("read_count", 32'(re_cnt), 32'd256);
        check("grant_after_read", 32'(mem_grant), 32'd0);

        // Reset after 100 bytes of a load
        wr_cnt = 0;
        send("w", 2);
        for (int n = 0; n < 100; n++) send(8'(n), 2);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        check("partial_write_count", 32'(wr_cnt), 32'd50);
        check("ram_word49_kept", 32'(ram[49]), 32'h6263);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back("P");
        send("p", 0);
        wait_drain(200, "ping_after_reset");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_cmd_ctrl.md
HOST_CMD_CTRL -- requirements
Module: host_cmd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: word address width of the program RAM.
REQ-002 Parameter MEM_WORDS, default 256: words transferred by 'r'/'w'; 2*MEM_WORDS bytes = 512.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte.
REQ-007 tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start.
REQ-008 tx_start  output  1  one-cycle pulse: transmit tx_data.
REQ-009 tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-010 mem_addr  output  ADDR_W  RAM word address.
REQ-011 mem_wdata  output  16  RAM write data.
REQ-012 mem_we  output  1  RAM write enable, one cycle per word.
REQ-013 mem_re  output  1  RAM read enable; mem_rdata valid exactly one cycle later.
REQ-014 mem_rdata  input  16  RAM read data.
REQ-015 mem_grant  output  1  high while controller owns the RAM port (r/w transfer active).
REQ-016 cpu_start  output  1  one-cycle pulse: MU0 starts at address 0.
REQ-017 cpu_running  input  1  MU0 execution in progress.

Function
REQ-018 States: IDLE, REPLY, RX_HI, RX_LO, WRITE, RD_REQ, RD_WAIT, TX_HI, TX_LO.
REQ-019 IDLE, rx_valid: 'p' -> REPLY 'P'; 's' -> REPLY '+' if cpu_running else '-'; 'x' -> cpu_start pulse next cycle, REPLY 'X'; 'w' -> RX_HI, addr 0; 'r' -> RD_REQ, addr 0; any other byte -> REPLY '?'.
REQ-020 'x', 'r', 'w' while cpu_running -> REPLY '!'; no cpu_start, no RAM access, mem_grant stays low.
REQ-021 REPLY: tx_start pulses once the first cycle tx_busy is low; return to IDLE the cycle after tx_start.
REQ-022 Never assert tx_start while tx_busy is high, nor on two consecutive cycles.
REQ-023 Write: RX_HI latches byte as word[15:8]; RX_LO latches word[7:0]; WRITE asserts mem_we one cycle at current addr, then addr+1.
REQ-024 After the write at addr MEM_WORDS-1 -> REPLY 'K'; address does not wrap beyond the transfer.
REQ-025 Read: RD_REQ asserts mem_re one cycle; RD_WAIT captures mem_rdata; TX_HI sends [15:8], TX_LO sends [7:0], each per REQ-021/022; then next addr or, after MEM_WORDS-1, IDLE with no trailing reply.
REQ-026 rx_valid in any state other than IDLE, RX_HI, RX_LO: byte dropped, no effect.
REQ-027 mem_grant high from the cycle after 'r'/'w' accepted until return to IDLE; mem_we/mem_re only asserted while mem_grant high.
REQ-028 cpu_start is never asserted while mem_grant is high.
REQ-029 Address counter ADDR_W+1 bits wide so MEM_WORDS = 2^ADDR_W terminates correctly.

Reset
REQ-030 rst_n low at posedge clk: state IDLE; tx_start, mem_we, mem_re, mem_grant, cpu_start 0; tx_data, mem_addr, mem_wdata 0; counters cleared.
REQ-031 Reset mid-transfer aborts it immediately; partially written RAM contents are left as-is; no reply sent.

Structure
REQ-032 Protocol byte constants ('p','r','w','x','s','P','K','X','+','-','?','!') and state encoding in shared package mu0_pkg.
REQ-033 One sub-module natural: tx_sched, which holds tx_data and issues tx_start per REQ-021/022, shared by REPLY and read-stream paths.

Verification
REQ-034 'p' -> exactly one tx_start with tx_data 'P'; module back in IDLE.
REQ-035 'w' + 512 bytes (byte n = n mod 256) -> 256 mem_we, word k = {2k mod 256, (2k+1) mod 256} at addr k, then reply 'K'.
REQ-036 'r' after REQ-035 -> 512 tx bytes equal to the written stream, tx_start never during tx_busy, no trailing byte.
REQ-037 cpu_running=1: 's' -> '+'; 'x' -> '!' with no cpu_start; 'r' -> '!' with mem_grant low; cpu_running=0: 'x' -> one cpu_start pulse, reply 'X'.
REQ-038 'q' -> '?'; extra bytes during read stream ignored; rst_n low after 100 bytes of 'w' -> all outputs 0, then 'p' -> 'P'.
